// File: rtl/local_max_pkg.sv
// Shared definitions for the local-maximum stream filter.
// Contents:
//   state_t      - sequencing states of the stream controller
//   NB_*         - neighbour slot indices (NW..SE) in the packed neighbour vector
//   EARLIER_MASK - neighbours that precede the centre in raster order
//   border_mask  - which neighbour slots lie inside the frame for a centre
//                  on the given frame edges
// Related macro: LOCAL_MAX_PLATEAU_EN (used by local_max_window_cmp).
package local_max_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int NB_NUM = 8;
  localparam int NB_NW  = 0;
  localparam int NB_N   = 1;
  localparam int NB_NE  = 2;
  localparam int NB_W   = 3;
  localparam int NB_E   = 4;
  localparam int NB_SW  = 5;
  localparam int NB_S   = 6;
  localparam int NB_SE  = 7;

  // NW, N, NE and W come before the centre in raster order.
  localparam logic [NB_NUM-1:0] EARLIER_MASK = 8'b0000_1111;

  // A neighbour slot is in-frame unless it crosses an edge the centre sits on.
  function automatic logic [NB_NUM-1:0] border_mask(input logic at_top,
                                                    input logic at_bottom,
                                                    input logic at_left,
                                                    input logic at_right);
    logic [NB_NUM-1:0] m;
    m        = 8'h00;
    m[NB_NW] = !(at_top || at_left);
    m[NB_N]  = !at_top;
    m[NB_NE] = !(at_top || at_right);
    m[NB_W]  = !at_left;
    m[NB_E]  = !at_right;
    m[NB_SW] = !(at_bottom || at_left);
    m[NB_S]  = !at_bottom;
    m[NB_SE] = !(at_bottom || at_right);
    return m;
  endfunction

endpackage

// File: rtl/local_max_window_cmp.sv
// Combinational 3x3 local-maximum decision for one centre pixel.
// Ports:
//   centre   - centre pixel value
//   nbrs     - eight neighbours packed by NB_* slot index (slot i at bits i*PIX_W)
//   nb_valid - 1 per slot whose neighbour lies inside the frame
//   is_max   - 1 when the centre is a local maximum
// Macro LOCAL_MAX_PLATEAU_EN: when defined, only equal neighbours earlier in
// raster order disqualify the centre (first pixel of a plateau wins); when
// undefined, any equal in-frame neighbour disqualifies it.
module local_max_window_cmp
  import local_max_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0]        centre,
  input  logic [NB_NUM*PIX_W-1:0] nbrs,
  input  logic [NB_NUM-1:0]       nb_valid,
  output logic                    is_max
);

  logic [NB_NUM-1:0] gt_s;
  logic [NB_NUM-1:0] eq_s;
  logic [NB_NUM-1:0] tie_mask_s;

  // Per-slot greater / equal flags; out-of-frame slots never take part.
  always_comb begin
    gt_s = '0;
    eq_s = '0;
    for (int i = 0; i < NB_NUM; i++) begin
      gt_s[i] = nb_valid[i] && (nbrs[i*PIX_W +: PIX_W] > centre);
      eq_s[i] = nb_valid[i] && (nbrs[i*PIX_W +: PIX_W] == centre);
    end
  end

`ifdef LOCAL_MAX_PLATEAU_EN
  assign tie_mask_s = EARLIER_MASK;
`else
  assign tie_mask_s = {NB_NUM{1'b1}};
`endif

  assign is_max = !(|gt_s) && !(|(eq_s & tie_mask_s));

endmodule

// File: rtl/local_max_stream.sv
// Streaming 3x3 local-maximum detector over raster-order frames.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  - pixel input stream (raster order)
//   m_valid/m_ready         - result handshake
//   m_data                  - centre pixel of the result
//   m_max                   - 1 when the centre is a local maximum
//   m_last                  - marks result (IMG_H-1, IMG_W-1)
// Macro LOCAL_MAX_PLATEAU_EN selects the plateau tie rule (see
// local_max_window_cmp); the default build uses the strict rule.
//
// The datapath is a raster delay line: every push (accepted pixel, or a zero
// during FLUSH) shifts one new column into the window. When push n lands, the
// centre being judged is raster index n-IMG_W-1, so the output lags the input
// by IMG_W+1 positions; FLUSH pushes IMG_W+1 dummy zeros to drain the tail.
module local_max_stream
  import local_max_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_max,
  output logic             m_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int FLS_W = $clog2(IMG_W + 2);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [FLS_W-1:0] FLUSH_LEN = FLS_W'(IMG_W + 1);

  state_t           state_r;
  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] out_col_r;
  logic [ROW_W-1:0] out_row_r;
  logic [COL_W-1:0] lb_ptr_r;
  logic [FLS_W-1:0] flush_cnt_r;

  logic [PIX_W-1:0] lb0_mem [IMG_W];
  logic [PIX_W-1:0] lb1_mem [IMG_W];

  // ea_* hold the newest column (east of centre after the next push shifts),
  // ce_* hold the column that becomes the west column after the next push.
  logic [PIX_W-1:0] ea_top_r, ea_mid_r, ea_bot_r;
  logic [PIX_W-1:0] ce_top_r, ce_mid_r, ce_bot_r;

  logic                    adv_s;
  logic                    in_fire_s;
  logic                    flush_step_s;
  logic                    push_s;
  logic                    produce_s;
  logic [PIX_W-1:0]        push_data_s;
  logic [PIX_W-1:0]        lb0_rd_s;
  logic [PIX_W-1:0]        lb1_rd_s;
  logic [NB_NUM*PIX_W-1:0] nbrs_s;
  logic [NB_NUM-1:0]       nb_valid_s;
  logic                    is_max_s;
  logic                    is_last_s;

  // The output register can take a new result when empty or being drained.
  assign adv_s        = !m_valid || m_ready;
  assign s_ready      = rst_n && (state_r != ST_FLUSH) && adv_s;
  assign in_fire_s    = s_valid && s_ready;
  assign flush_step_s = (state_r == ST_FLUSH) && adv_s;
  assign push_s       = in_fire_s || flush_step_s;
  assign produce_s    = ((state_r == ST_RUN) && in_fire_s) || flush_step_s;

  assign lb0_rd_s = lb0_mem[lb_ptr_r];
  assign lb1_rd_s = lb1_mem[lb_ptr_r];

  // FLUSH feeds zeros; they only ever land in out-of-frame (masked) slots.
  always_comb begin
    push_data_s = '0;
    if (state_r == ST_FLUSH) begin
      push_data_s = '0;
    end else begin
      push_data_s = s_data;
    end
  end

  // Window as it will look after this push; centre is ea_mid_r.
  always_comb begin
    nbrs_s = '0;
    nbrs_s[NB_NW*PIX_W +: PIX_W] = ce_top_r;
    nbrs_s[NB_N*PIX_W  +: PIX_W] = ea_top_r;
    nbrs_s[NB_NE*PIX_W +: PIX_W] = lb1_rd_s;
    nbrs_s[NB_W*PIX_W  +: PIX_W] = ce_mid_r;
    nbrs_s[NB_E*PIX_W  +: PIX_W] = lb0_rd_s;
    nbrs_s[NB_SW*PIX_W +: PIX_W] = ce_bot_r;
    nbrs_s[NB_S*PIX_W  +: PIX_W] = ea_bot_r;
    nbrs_s[NB_SE*PIX_W +: PIX_W] = push_data_s;
  end

  // Edge masking also hides stale line-buffer and wrapped-row data.
  assign nb_valid_s = border_mask(out_row_r == '0, out_row_r == ROW_LAST,
                                  out_col_r == '0, out_col_r == COL_LAST);
  assign is_last_s  = (out_row_r == ROW_LAST) && (out_col_r == COL_LAST);

  local_max_window_cmp #(
    .PIX_W (PIX_W)
  ) u_cmp (
    .centre   (ea_mid_r),
    .nbrs     (nbrs_s),
    .nb_valid (nb_valid_s),
    .is_max   (is_max_s)
  );

  // Line buffers: each slot delays the stream by exactly IMG_W pushes.
  always_ff @(posedge clk) begin
    if (push_s) begin
      lb0_mem[lb_ptr_r] <= push_data_s;
      lb1_mem[lb_ptr_r] <= lb0_rd_s;
    end
  end

  // Window column shift on every push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_top_r <= '0;
      ea_mid_r <= '0;
      ea_bot_r <= '0;
      ce_top_r <= '0;
      ce_mid_r <= '0;
      ce_bot_r <= '0;
    end else if (push_s) begin
      ce_top_r <= ea_top_r;
      ce_mid_r <= ea_mid_r;
      ce_bot_r <= ea_bot_r;
      ea_top_r <= lb1_rd_s;
      ea_mid_r <= lb0_rd_s;
      ea_bot_r <= push_data_s;
    end
  end

  // Input position, result position and line-buffer pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r     <= '0;
      row_r     <= '0;
      out_col_r <= '0;
      out_row_r <= '0;
      lb_ptr_r  <= '0;
    end else begin
      if (in_fire_s) begin
        if (col_r == COL_LAST) begin
          col_r <= '0;
          row_r <= (row_r == ROW_LAST) ? '0 : row_r + ROW_W'(1);
        end else begin
          col_r <= col_r + COL_W'(1);
        end
      end
      if (produce_s) begin
        if (out_col_r == COL_LAST) begin
          out_col_r <= '0;
          out_row_r <= (out_row_r == ROW_LAST) ? '0 : out_row_r + ROW_W'(1);
        end else begin
          out_col_r <= out_col_r + COL_W'(1);
        end
      end
      if (push_s) begin
        lb_ptr_r <= (lb_ptr_r == COL_LAST) ? '0 : lb_ptr_r + COL_W'(1);
      end
    end
  end

  // Frame sequencing: IDLE -> FILL -> RUN -> FLUSH -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_fire_s) state_r <= ST_FILL;
        end
        ST_FILL: begin
          // Pixel (1,0) is the last one needed before the first result.
          if (in_fire_s && (row_r == ROW_W'(1)) && (col_r == '0)) state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (in_fire_s && (row_r == ROW_LAST) && (col_r == COL_LAST)) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= FLUSH_LEN;
          end
        end
        ST_FLUSH: begin
          if (flush_step_s) begin
            flush_cnt_r <= flush_cnt_r - FLS_W'(1);
            if (flush_cnt_r == FLS_W'(1)) state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          flush_cnt_r <= '0;
        end
      endcase
    end
  end

  // Result register; holds its contents while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_max   <= 1'b0;
      m_last  <= 1'b0;
    end else if (produce_s) begin
      m_valid <= 1'b1;
      m_data  <= ea_mid_r;
      m_max   <= is_max_s;
      m_last  <= is_last_s;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_local_max_stream.sv
// Self-checking bench for local_max_stream (IMG_W=4, IMG_H=4, PIX_W=8).
// Expected results are computed from each image by a reference model and
// queued when the frame is driven; the monitor compares them as results
// leave the DUT. Honours LOCAL_MAX_PLATEAU_EN in the same way as the design.
module tb_local_max_stream;

  localparam int PIX_W = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int NPIX  = IMG_W * IMG_H;

`ifdef LOCAL_MAX_PLATEAU_EN
  localparam int T1_MAX = 1;
  localparam int T2_MAX = 2;
`else
  localparam int T1_MAX = 0;
  localparam int T2_MAX = 1;
`endif

  typedef logic [PIX_W-1:0] img_t [NPIX];
  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             max;
    logic             last;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [PIX_W-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [PIX_W-1:0] m_data;
  logic             m_max;
  logic             m_last;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t exp_q[$];
  int   res_idx  = 0;
  int   max_seen = 0;
  bit   ready_toggle = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;
  int   cyc = 0;
  bit   prev_stall = 1'b0;

  always #5 clk = ~clk;

  local_max_stream #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_max   (m_max),
    .m_last  (m_last)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic model_max(input img_t img, input int r, input int c);
    logic [PIX_W-1:0] ctr;
    logic [PIX_W-1:0] nb;
    ctr = img[r*IMG_W + c];
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr == 0 && dc == 0) continue;
        if (r + dr < 0 || r + dr >= IMG_H || c + dc < 0 || c + dc >= IMG_W) continue;
        nb = img[(r + dr)*IMG_W + (c + dc)];
        if (nb > ctr) return 1'b0;
        if (nb == ctr) begin
`ifdef LOCAL_MAX_PLATEAU_EN
          if (dr < 0 || (dr == 0 && dc < 0)) return 1'b0;
`else
          return 1'b0;
`endif
        end
      end
    end
    return 1'b1;
  endfunction

  task automatic push_expected(input img_t img);
    res_t e;
    for (int p = 0; p < NPIX; p++) begin
      e.data = img[p];
      e.max  = model_max(img, p / IMG_W, p % IMG_W);
      e.last = (p == NPIX - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_pixels(input img_t img, input int npix, output int first_stall);
    int stalls;
    bit acc;
    first_stall = 0;
    for (int p = 0; p < npix; p++) begin
      s_valid = 1'b1;
      s_data  = img[p];
      stalls  = 0;
      acc     = 1'b0;
      while (!acc && stalls < 1000) begin
        @(negedge clk);
        acc = s_ready;
        if (!acc) stalls++;
        @(posedge clk);
        #1;
      end
      if (!acc) check_val("accept_timeout", stalls, 0);
      if (p == 0) first_stall = stalls;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check_val(tag, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_idle_valid"}, m_valid, 0);
  endtask

  task automatic start_test();
    res_idx  = 0;
    max_seen = 0;
  endtask

  // m_ready source: constant 1, or the repeating 1,0,0,1 pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      m_ready = ready_toggle ? rdy_pat[cyc % 4] : 1'b1;
    end
  end

  // Result monitor, sampled mid-cycle; a transfer happens at the next rising edge.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) check_val("stall_hold_valid", m_valid, 1);
        if (m_valid) begin
          if (exp_q.size() == 0) begin
            check_val("spurious_result", m_valid, 0);
          end else begin
            e = exp_q[0];
            check_val($sformatf("data[%0d]", res_idx), m_data, e.data);
            check_val($sformatf("max[%0d]", res_idx), m_max, e.max);
            check_val($sformatf("last[%0d]", res_idx), m_last, e.last);
            if (m_ready) begin
              void'(exp_q.pop_front());
              res_idx++;
              if (m_max) max_seen++;
            end
          end
        end
        prev_stall = m_valid && !m_ready;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d results pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    img_t img_a, img_b, img_c;
    int st;

    foreach (img_a[i]) img_a[i] = 8'h10;
    foreach (img_b[i]) img_b[i] = 8'h00;
    img_b[1*IMG_W + 2] = 8'hFF;
    foreach (img_c[i]) img_c[i] = PIX_W'($urandom_range(0, 3));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_m_data", m_data, 0);
    check_val("rst_m_max", m_max, 0);
    check_val("rst_m_last", m_last, 0);
    check_val("rst_s_ready", s_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("ready_after_reset", s_ready, 1);

    // Flat frame: plateau rule decides
    start_test();
    push_expected(img_a);
    drive_pixels(img_a, NPIX, st);
    wait_drain("t1_drain");
    check_val("t1_max_count", max_seen, T1_MAX);

    // Single peak at (1,2)
    start_test();
    push_expected(img_b);
    drive_pixels(img_b, NPIX, st);
    wait_drain("t2_drain");
    check_val("t2_max_count", max_seen, T2_MAX);
    check_val("t2_results", res_idx, NPIX);

    // Backpressure with m_ready 1,0,0,1
    start_test();
    ready_toggle = 1'b1;
    push_expected(img_c);
    drive_pixels(img_c, NPIX, st);
    wait_drain("t3_drain");
    ready_toggle = 1'b0;
    check_val("t3_results", res_idx, NPIX);

    // Back-to-back frames with s_valid held high
    start_test();
    push_expected(img_c);
    drive_pixels(img_c, NPIX, st);
    push_expected(img_b);
    drive_pixels(img_b, NPIX, st);
    check_val("t4_flush_stall", st, IMG_W + 1);
    wait_drain("t4_drain");
    check_val("t4_results", res_idx, 2 * NPIX);

    // Reset after 7 pixels, then a clean frame
    start_test();
    push_expected(img_c);
    drive_pixels(img_c, 7, st);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_m_valid", m_valid, 0);
    check_val("t5_rst_s_ready", s_ready, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_test();
    push_expected(img_b);
    drive_pixels(img_b, NPIX, st);
    wait_drain("t5_drain");
    check_val("t5_results", res_idx, NPIX);
    check_val("t5_max_count", max_seen, T2_MAX);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
